id_stage_piped: RTL and testbench

- Parametrised successor to the ARM decode stage.
- Decodes one 32-bit instruction per cycle and reads operands from an internal register file with same-cycle write-back bypass.
- Detects RAW hazards against the EXE and MEM stages, in either forwarding or non-forwarding mode.
- Captures all decoded fields in an internal ID/EXE pipeline register with freeze/flush/bubble control.
- Sits between the IF/ID register and the execute stage.

---
 rtl/id_stage_piped.sv | 241 ++++++++++++++++++++++++
 tb/tb_id_stage_piped.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_piped.sv
// ARM-style instruction decode stage: field decode, condition check, bypassed
// register file, RAW hazard detection and the ID/EXE pipeline register.
module id_stage_piped #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned PC_W     = 32,
   parameter int unsigned NUM_REGS = 16,
   parameter bit          FWD_EN   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic              instr_valid,
   input  logic [PC_W-1:0]   pc_in,
   input  logic [31:0]       instr,
   input  logic [3:0]        status,
   input  logic              wb_en,
   input  logic [3:0]        wb_dest,
   input  logic [DATA_W-1:0] wb_value,
   input  logic              exe_wb_en,
   input  logic              exe_mem_read,
   input  logic [3:0]        exe_dest,
   input  logic              mem_wb_en,
   input  logic [3:0]        mem_dest,
   output logic              hazard,
   output logic              valid_out,
   output logic              s_update,
   output logic              branch,
   output logic              mem_w_en,
   output logic              mem_r_en,
   output logic              wb_en_out,
   output logic [3:0]        exe_cmd,
   output logic [DATA_W-1:0] val_rn,
   output logic [DATA_W-1:0] val_rm,
   output logic [PC_W-1:0]   pc_out,
   output logic [23:0]       imm24,
   output logic [11:0]       shift_operand,
   output logic [3:0]        rd,
   output logic [3:0]        src1_out,
   output logic [3:0]        src2_out,
   output logic              imm
);

   localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   typedef struct packed {
      logic              valid;
      logic              s_update;
      logic              branch;
      logic              mem_w;
      logic              mem_r;
      logic              wb;
      logic [3:0]        cmd;
      logic [DATA_W-1:0] rn;
      logic [DATA_W-1:0] rm;
      logic [PC_W-1:0]   pc;
      logic [23:0]       imm24;
      logic [11:0]       shop;
      logic [3:0]        rd;
      logic [3:0]        s1;
      logic [3:0]        s2;
      logic              imm;
   } idex_t;

   logic [3:0] cond, opcode, rn_a, rd_a, rm_a;
   logic [1:0] mode;
   logic       i_bit, s_bit;

   assign cond   = instr[31:28];
   assign mode   = instr[27:26];
   assign i_bit  = instr[25];
   assign opcode = instr[24:21];
   assign s_bit  = instr[20];
   assign rn_a   = instr[19:16];
   assign rd_a   = instr[15:12];
   assign rm_a   = instr[3:0];

   logic [3:0] dec_cmd;
   logic       dec_wb, dec_mr, dec_mw, dec_br, dec_s;
   logic       is_str, use1, use2;

   always_comb begin
      dec_cmd = '0;
      dec_wb  = 1'b0;
      dec_mr  = 1'b0;
      dec_mw  = 1'b0;
      dec_br  = 1'b0;
      dec_s   = 1'b0;
      is_str  = 1'b0;
      use1    = 1'b1;
      case (mode)
         2'b00: begin
            dec_s  = s_bit;
            dec_wb = 1'b1;
            case (opcode)
               4'b1101: begin dec_cmd = 4'b0001; use1 = 1'b0; end
               4'b1111: begin dec_cmd = 4'b1001; use1 = 1'b0; end
               4'b0100: dec_cmd = 4'b0010;
               4'b0101: dec_cmd = 4'b0011;
               4'b0010: dec_cmd = 4'b0100;
               4'b0110: dec_cmd = 4'b0101;
               4'b0000: dec_cmd = 4'b0110;
               4'b1100: dec_cmd = 4'b0111;
               4'b0001: dec_cmd = 4'b1000;
               4'b1010: begin dec_cmd = 4'b0100; dec_wb = 1'b0; end
               4'b1000: begin dec_cmd = 4'b0110; dec_wb = 1'b0; end
               default: begin dec_wb = 1'b0; dec_s = 1'b0; end
            endcase
         end
         2'b01: begin
            dec_cmd = 4'b0010;
            if (s_bit) begin
               dec_mr = 1'b1;
               dec_wb = 1'b1;
            end else begin
               dec_mw = 1'b1;
               is_str = 1'b1;
            end
         end
         2'b10: begin
            dec_br = 1'b1;
            use1   = 1'b0;
         end
         default: use1 = 1'b0;
      endcase
   end

   assign use2 = is_str || (mode == 2'b00 && !i_bit);

   logic [3:0] src1, src2;
   assign src1 = rn_a;
   assign src2 = is_str ? rd_a : rm_a;

   logic n_f, z_f, c_f, v_f, cond_ok;
   assign {n_f, z_f, c_f, v_f} = status;

   always_comb begin
      case (cond)
         4'h0:    cond_ok = z_f;
         4'h1:    cond_ok = !z_f;
         4'h2:    cond_ok = c_f;
         4'h3:    cond_ok = !c_f;
         4'h4:    cond_ok = n_f;
         4'h5:    cond_ok = !n_f;
         4'h6:    cond_ok = v_f;
         4'h7:    cond_ok = !v_f;
         4'h8:    cond_ok = c_f && !z_f;
         4'h9:    cond_ok = !c_f || z_f;
         4'ha:    cond_ok = (n_f == v_f);
         4'hb:    cond_ok = (n_f != v_f);
         4'hc:    cond_ok = !z_f && (n_f == v_f);
         4'hd:    cond_ok = z_f || (n_f != v_f);
         4'he:    cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   function automatic logic in_range(input logic [3:0] a);
      return 32'(a) < NUM_REGS;
   endfunction

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] rd_rn, rd_rm;

   // Unimplemented addresses read 0 even when a write to them is in flight.
   always_comb begin
      rd_rn = '0;
      rd_rm = '0;
      if (in_range(src1))
         rd_rn = (wb_en && wb_dest == src1) ? wb_value : regs[src1[IDX_W-1:0]];
      if (in_range(src2))
         rd_rm = (wb_en && wb_dest == src2) ? wb_value : regs[src2[IDX_W-1:0]];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wb_en && in_range(wb_dest)) begin
         regs[wb_dest[IDX_W-1:0]] <= wb_value;
      end
   end

   logic exe_hit, mem_hit;
   assign exe_hit = exe_wb_en && ((use1 && exe_dest == src1) || (use2 && exe_dest == src2));
   assign mem_hit = mem_wb_en && ((use1 && mem_dest == src1) || (use2 && mem_dest == src2));
   assign hazard  = instr_valid && (FWD_EN ? (exe_mem_read && exe_hit) : (exe_hit || mem_hit));

   idex_t load, pipe;
   logic  bubble;
   assign bubble = hazard || !instr_valid || !cond_ok;

   // Data fields load even on a bubble; only control and valid are squashed.
   always_comb begin
      load       = '0;
      load.rn    = rd_rn;
      load.rm    = rd_rm;
      load.pc    = pc_in;
      load.imm24 = instr[23:0];
      load.shop  = instr[11:0];
      load.rd    = rd_a;
      load.s1    = src1;
      load.s2    = src2;
      load.imm   = i_bit;
      if (!bubble) begin
         load.valid    = 1'b1;
         load.s_update = dec_s;
         load.branch   = dec_br;
         load.mem_w    = dec_mw;
         load.mem_r    = dec_mr;
         load.wb       = dec_wb;
         load.cmd      = dec_cmd;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         pipe <= '0;
      else if (flush)
         pipe <= '0;
      else if (!freeze)
         pipe <= load;
   end

   assign valid_out     = pipe.valid;
   assign s_update      = pipe.s_update;
   assign branch        = pipe.branch;
   assign mem_w_en      = pipe.mem_w;
   assign mem_r_en      = pipe.mem_r;
   assign wb_en_out     = pipe.wb;
   assign exe_cmd       = pipe.cmd;
   assign val_rn        = pipe.rn;
   assign val_rm        = pipe.rm;
   assign pc_out        = pipe.pc;
   assign imm24         = pipe.imm24;
   assign shift_operand = pipe.shop;
   assign rd            = pipe.rd;
   assign src1_out      = pipe.s1;
   assign src2_out      = pipe.s2;
   assign imm           = pipe.imm;

endmodule

// File: tb/tb_id_stage_piped.sv
// Scoreboard bench for id_stage_piped: three configurations share one stimulus
// stream and are checked against a behavioural reference model.
module tb_id_stage_piped;

   typedef struct packed {
      logic        valid;
      logic        s_update;
      logic        branch;
      logic        mem_w;
      logic        mem_r;
      logic        wb;
      logic [3:0]  cmd;
      logic [31:0] rn;
      logic [31:0] rm;
      logic [31:0] pc;
      logic [23:0] imm24;
      logic [11:0] shop;
      logic [3:0]  rd;
      logic [3:0]  s1;
      logic [3:0]  s2;
      logic        imm;
   } out_t;

   typedef struct packed {
      logic        rst;
      logic        freeze;
      logic        flush;
      logic        iv;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [3:0]  status;
      logic        wb_en;
      logic [3:0]  wb_dest;
      logic [31:0] wb_value;
      logic        exe_wb_en;
      logic        exe_mem_read;
      logic [3:0]  exe_dest;
      logic        mem_wb_en;
      logic [3:0]  mem_dest;
   } in_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        freeze = 1'b0, flush = 1'b0, instr_valid = 1'b0;
   logic [31:0] pc_in = '0, instr = '0, wb_value = '0;
   logic [3:0]  status = '0, wb_dest = '0, exe_dest = '0, mem_dest = '0;
   logic        wb_en = 1'b0, exe_wb_en = 1'b0, exe_mem_read = 1'b0, mem_wb_en = 1'b0;

   always #5 clk = ~clk;

   out_t got [3];
   logic got_hz [3];

   // dut 0: forwarding, 16 regs; dut 1: no forwarding; dut 2: forwarding, 8 regs
   for (genvar k = 0; k < 3; k++) begin : g_dut
      logic        hz, v, su, br, mw, mr, wbo, im;
      logic [3:0]  cmd, rdo, s1, s2;
      logic [31:0] rn, rm, pco;
      logic [23:0] i24;
      logic [11:0] sh;
      id_stage_piped #(
         .DATA_W(32), .PC_W(32), .NUM_REGS(k == 2 ? 8 : 16), .FWD_EN(k != 1)
      ) dut (
         .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
         .instr_valid(instr_valid), .pc_in(pc_in), .instr(instr), .status(status),
         .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
         .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read), .exe_dest(exe_dest),
         .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
         .hazard(hz), .valid_out(v), .s_update(su), .branch(br), .mem_w_en(mw),
         .mem_r_en(mr), .wb_en_out(wbo), .exe_cmd(cmd), .val_rn(rn), .val_rm(rm),
         .pc_out(pco), .imm24(i24), .shift_operand(sh), .rd(rdo),
         .src1_out(s1), .src2_out(s2), .imm(im)
      );
      assign got[k]    = {v, su, br, mw, mr, wbo, cmd, rn, rm, pco, i24, sh, rdo, s1, s2, im};
      assign got_hz[k] = hz;
   end

   int tests = 0;
   int fails = 0;

   out_t [2:0] exp_oq[$];
   logic [2:0] exp_hq[$];

   out_t        st [3];
   logic [31:0] rf [16];

   function automatic in_t idle();
      in_t s = '0;
      s.rst    = 1'b1;
      s.status = 4'b0000;
      return s;
   endfunction

   // Data-processing table: 0 = undefined, 1 = writes back, 2 = compare/test.
   function automatic int alu_lookup(input logic [3:0] op, output logic [3:0] cmd);
      cmd = 4'd0;
      case (op)
         4'hD: begin cmd = 4'd1; return 1; end
         4'hF: begin cmd = 4'd9; return 1; end
         4'h4: begin cmd = 4'd2; return 1; end
         4'h5: begin cmd = 4'd3; return 1; end
         4'h2: begin cmd = 4'd4; return 1; end
         4'h6: begin cmd = 4'd5; return 1; end
         4'h0: begin cmd = 4'd6; return 1; end
         4'hC: begin cmd = 4'd7; return 1; end
         4'h1: begin cmd = 4'd8; return 1; end
         4'hA: begin cmd = 4'd4; return 2; end
         4'h8: begin cmd = 4'd6; return 2; end
         default: return 0;
      endcase
   endfunction

   // Odd codes are the negation of the preceding even code; 1111 never passes.
   function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, base;
      {n, z, cy, v} = f;
      case (c[3:1])
         3'd0:    base = z;
         3'd1:    base = cy;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = cy & ~z;
         3'd5:    base = (n == v);
         3'd6:    base = ~z & (n == v);
         default: base = 1'b1;
      endcase
      if (c == 4'hF) return 1'b0;
      return c[0] ? ~base : base;
   endfunction

   function automatic logic [31:0] rf_read(input logic [3:0] a, input int nr, input in_t s);
      if (int'(a) >= nr) return 32'd0;
      if (s.wb_en && s.wb_dest == a) return s.wb_value;
      return rf[a];
   endfunction

   task automatic drive(input in_t s);
      out_t [2:0] eo;
      logic [2:0] eh;
      rst = s.rst; freeze = s.freeze; flush = s.flush; instr_valid = s.iv;
      pc_in = s.pc; instr = s.instr; status = s.status;
      wb_en = s.wb_en; wb_dest = s.wb_dest; wb_value = s.wb_value;
      exe_wb_en = s.exe_wb_en; exe_mem_read = s.exe_mem_read; exe_dest = s.exe_dest;
      mem_wb_en = s.mem_wb_en; mem_dest = s.mem_dest;
      for (int k = 0; k < 3; k++) begin
         logic        fwd, sb, ib, is_str, use1, use2, eh_k, mh_k, haz;
         logic [1:0]  mode;
         logic [3:0]  op, src1, src2, cmd;
         int          nr, kind;
         out_t        nx;
         fwd    = (k != 1);
         nr     = (k == 2) ? 8 : 16;
         mode   = s.instr[27:26];
         ib     = s.instr[25];
         op     = s.instr[24:21];
         sb     = s.instr[20];
         is_str = (mode == 2'b01) && !sb;
         kind   = alu_lookup(op, cmd);
         src1   = s.instr[19:16];
         src2   = is_str ? s.instr[15:12] : s.instr[3:0];
         use1   = !((mode == 2'b00 && (op == 4'hD || op == 4'hF)) || mode[1]);
         use2   = is_str || (mode == 2'b00 && !ib);
         eh_k   = s.exe_wb_en && ((use1 && s.exe_dest == src1) || (use2 && s.exe_dest == src2));
         mh_k   = s.mem_wb_en && ((use1 && s.mem_dest == src1) || (use2 && s.mem_dest == src2));
         haz    = s.iv && (fwd ? (s.exe_mem_read && eh_k) : (eh_k || mh_k));
         eh[k]  = haz;
         if (!s.rst || s.flush) begin
            nx = '0;
         end else if (s.freeze) begin
            nx = st[k];
         end else begin
            nx       = '0;
            nx.rn    = rf_read(src1, nr, s);
            nx.rm    = rf_read(src2, nr, s);
            nx.pc    = s.pc;
            nx.imm24 = s.instr[23:0];
            nx.shop  = s.instr[11:0];
            nx.rd    = s.instr[15:12];
            nx.s1    = src1;
            nx.s2    = src2;
            nx.imm   = ib;
            if (!haz && s.iv && cond_holds(s.instr[31:28], s.status)) begin
               nx.valid = 1'b1;
               if (mode == 2'b00 && kind != 0) begin
                  nx.cmd      = cmd;
                  nx.wb       = (kind == 1);
                  nx.s_update = sb;
               end else if (mode == 2'b01) begin
                  nx.cmd   = 4'd2;
                  nx.mem_r = sb;
                  nx.wb    = sb;
                  nx.mem_w = !sb;
               end else if (mode == 2'b10) begin
                  nx.branch = 1'b1;
               end
            end
         end
         st[k] = nx;
         eo[k] = nx;
      end
      if (!s.rst)
         for (int i = 0; i < 16; i++) rf[i] = 32'd0;
      else if (s.wb_en)
         rf[s.wb_dest] = s.wb_value;
      exp_hq.push_back(eh);
      exp_oq.push_back(eo);
   endtask

   // Monitor: hazard is checked mid-cycle, registered outputs just after the edge.
   initial begin
      out_t [2:0] eo;
      logic [2:0] eh;
      forever begin
         @(negedge clk);
         if (exp_hq.size() > 0) begin
            eh = exp_hq.pop_front();
            for (int k = 0; k < 3; k++) begin
               tests++;
               if (got_hz[k] !== eh[k]) begin
                  fails++;
                  $display("FAIL hazard dut%0d t=%0t: got %b expected %b", k, $time, got_hz[k], eh[k]);
               end
            end
         end
         @(posedge clk);
         #1;
         if (exp_oq.size() > 0) begin
            eo = exp_oq.pop_front();
            for (int k = 0; k < 3; k++) begin
               tests++;
               if (got[k] !== eo[k]) begin
                  fails++;
                  $display("FAIL idex dut%0d t=%0t: got %h expected %h", k, $time, got[k], eo[k]);
               end
            end
         end
      end
   end

   task automatic step(input in_t s);
      @(posedge clk);
      #2;
      drive(s);
   endtask

   initial begin
      in_t s;
      for (int i = 0; i < 3; i++) st[i] = '0;
      for (int i = 0; i < 16; i++) rf[i] = 32'd0;

      s = idle(); s.rst = 1'b0;
      step(s); step(s);
      s = idle();
      step(s);

      s = idle(); s.iv = 1'b1; s.instr = 32'hE0831003; s.pc = 32'h100;
      s.wb_en = 1'b1; s.wb_dest = 4'd3; s.wb_value = 32'hDEAD;
      step(s);

      s = idle(); s.iv = 1'b1; s.instr = 32'hE0831002; s.pc = 32'h104;
      s.exe_wb_en = 1'b1; s.exe_mem_read = 1'b1; s.exe_dest = 4'd3;
      step(s);
      s.exe_mem_read = 1'b0;
      step(s);
      s.exe_wb_en = 1'b0; s.mem_wb_en = 1'b1; s.mem_dest = 4'd2;
      step(s);

      s = idle(); s.iv = 1'b1; s.instr = 32'h00831002; s.status = 4'b0000;
      step(s);
      s.status = 4'b0100;
      step(s);

      s = idle(); s.iv = 1'b1; s.instr = 32'hE5821004; s.pc = 32'h200;
      step(s);
      s.freeze = 1'b1; s.instr = 32'hE0812003; s.pc = 32'h204;
      step(s); step(s);
      s.flush = 1'b1;
      step(s);

      s = idle(); s.iv = 1'b1; s.instr = 32'hE3A00005;
      s.exe_wb_en = 1'b1; s.exe_mem_read = 1'b1; s.exe_dest = 4'd0;
      step(s);

      s = idle(); s.wb_en = 1'b1; s.wb_dest = 4'd12; s.wb_value = 32'd7;
      step(s);
      s = idle(); s.iv = 1'b1; s.instr = 32'hE08C100C;
      step(s);

      s = idle(); s.rst = 1'b0; s.iv = 1'b1; s.instr = 32'hE08C100C;
      step(s);
      s.rst = 1'b1;
      step(s);

      for (int i = 0; i < 400; i++) begin
         s = idle();
         s.rst          = ($urandom_range(99) != 0);
         s.freeze       = ($urandom_range(9) == 0);
         s.flush        = ($urandom_range(15) == 0);
         s.iv           = ($urandom_range(9) != 0);
         s.pc           = $urandom;
         s.instr        = $urandom;
         if ($urandom_range(3) != 0) s.instr[31:28] = 4'hE;
         if ($urandom_range(2) != 0) s.instr[27] = 1'b0;
         s.status       = 4'($urandom);
         s.wb_en        = ($urandom_range(1) != 0);
         s.wb_dest      = 4'($urandom);
         s.wb_value     = $urandom;
         s.exe_wb_en    = ($urandom_range(1) != 0);
         s.exe_mem_read = ($urandom_range(1) != 0);
         s.exe_dest     = 4'($urandom);
         s.mem_wb_en    = ($urandom_range(1) != 0);
         s.mem_dest     = 4'($urandom);
         step(s);
      end

      repeat (3) @(posedge clk);
      #2;
      tests++;
      if (exp_oq.size() != 0 || exp_hq.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d/%0d pending entries expected 0/0", exp_oq.size(), exp_hq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
